// File: rtl/jtframe_pocket_pkg.sv
// Shared definitions for the Pocket scaler-slot re-timer.
//   APF_CMD_W : width of the scaler-slot field carried in the command word
//   APF_BLANK : colour driven on blank pixels that carry no command
//   geom_t    : {width, height} pair, wide enough for any HW/VW up to 16 bits
package jtframe_pocket_pkg;

   localparam int APF_CMD_W = 3;
   localparam logic [23:0] APF_BLANK = 24'd0;

   typedef struct packed {
      logic [15:0] w;
      logic [15:0] h;
   } geom_t;

   function automatic geom_t mk_geom(input logic [15:0] w, input logic [15:0] h);
      geom_t g;
      g.w = w;
      g.h = h;
      return g;
   endfunction

endpackage

// File: rtl/jtframe_pocket_geom.sv
// Frame geometry measurement.
//   clk, rst   : system clock, synchronous active-high reset
//   pxl_cen    : pixel strobe; all state advances only when high
//   de, vs     : undelayed data enable and vsync from the video stage
//   width      : active pixels per line of the last complete frame
//   height     : active lines of the last complete frame
//   geom_ok    : the last STABLE_FR+1 captured geometries were identical and nonzero
module jtframe_pocket_geom
   import jtframe_pocket_pkg::*;
#(
   parameter int HW        = 10,
   parameter int VW        = 9,
   parameter int STABLE_FR = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          de,
   input  logic          vs,
   output logic [HW-1:0] width,
   output logic [VW-1:0] height,
   output logic          geom_ok
);

   localparam logic [1:0]    STABLE_TOP = 2'(STABLE_FR);
   localparam logic [HW-1:0] PIX_ONE    = HW'(1);
   localparam logic [VW-1:0] LINE_ONE   = VW'(1);

   logic          prev_de, fall_d, fall, same;
   logic [HW-1:0] pix_cnt, pix_inc, line_len, width_nxt;
   logic [VW-1:0] line_cnt, line_inc, height_nxt;
   logic [1:0]    stable_cnt;
   geom_t         g_new, g_old;

   always_comb begin
      fall       = prev_de & ~de;
      pix_inc    = (pix_cnt  == '1) ? pix_cnt  : pix_cnt  + PIX_ONE;
      line_inc   = (line_cnt == '1) ? line_cnt : line_cnt + LINE_ONE;
      // a line ending on the vsync strobe belongs to the frame being captured
      width_nxt  = fall ? pix_cnt  : line_len;
      height_nxt = fall ? line_inc : line_cnt;
      g_new      = mk_geom(16'(width_nxt), 16'(height_nxt));
      g_old      = mk_geom(16'(width), 16'(height));
      same       = (g_new == g_old) && (g_new != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_de    <= 1'b0;
         fall_d     <= 1'b0;
         pix_cnt    <= '0;
         line_len   <= '0;
         line_cnt   <= '0;
         width      <= '0;
         height     <= '0;
         stable_cnt <= '0;
      end else if (pxl_cen) begin
         prev_de <= de;
         fall_d  <= fall;
         // the counter still holds the finished line on the falling strobe,
         // and restarts one strobe later (at 1 if a new line already began)
         if (de) begin
            pix_cnt <= fall_d ? PIX_ONE : pix_inc;
         end else if (fall_d) begin
            pix_cnt <= '0;
         end
         if (vs) begin
            width    <= width_nxt;
            height   <= height_nxt;
            line_cnt <= '0;
            line_len <= '0;
            if (same) begin
               stable_cnt <= (stable_cnt == STABLE_TOP) ? stable_cnt : stable_cnt + 2'd1;
            end else begin
               stable_cnt <= '0;
            end
         end else if (fall) begin
            line_cnt <= line_inc;
            line_len <= pix_cnt;
         end
      end
   end

   assign geom_ok = (stable_cnt == STABLE_TOP);

endmodule

// File: rtl/jtframe_pocket_slot.sv
// Pocket video re-timer with APF scaler-slot command insertion.
//   clk, rst          : system clock, synchronous active-high reset
//   pxl_cen           : pixel strobe qualifying every input pixel
//   in_rgb/de/hs/vs   : video bus from the upstream Pocket stage
//   slot_req          : requested scaler slot, latched at vsync
//   out_rgb/de/hs/vs  : bus delayed by one strobe; the first blank pixel
//                       after each active run carries the slot command word
//   width, height     : geometry of the last complete frame
//   geom_ok           : geometry stable for STABLE_FR frames
module jtframe_pocket_slot
   import jtframe_pocket_pkg::*;
#(
   parameter int HW        = 10,
   parameter int VW        = 9,
   parameter int STABLE_FR = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic [23:0]   in_rgb,
   input  logic          in_de,
   input  logic          in_hs,
   input  logic          in_vs,
   input  logic [2:0]    slot_req,
   output logic [23:0]   out_rgb,
   output logic          out_de,
   output logic          out_hs,
   output logic          out_vs,
   output logic [HW-1:0] width,
   output logic [VW-1:0] height,
   output logic          geom_ok
);

   logic [APF_CMD_W-1:0] slot_act;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_rgb  <= APF_BLANK;
         out_de   <= 1'b0;
         out_hs   <= 1'b0;
         out_vs   <= 1'b0;
         slot_act <= '0;
      end else if (pxl_cen) begin
         out_de <= in_de;
         out_hs <= in_hs;
         out_vs <= in_vs;
         // out_de still holds the previous in_de, so out_de & ~in_de is the falling edge
         if (in_de) begin
            out_rgb <= in_rgb;
         end else if (out_de) begin
            out_rgb <= 24'(slot_act);
         end else begin
            out_rgb <= APF_BLANK;
         end
         if (in_vs) begin
            slot_act <= slot_req;
         end
      end
   end

   jtframe_pocket_geom #(
      .HW        (HW),
      .VW        (VW),
      .STABLE_FR (STABLE_FR)
   ) u_geom (
      .clk     (clk),
      .rst     (rst),
      .pxl_cen (pxl_cen),
      .de      (in_de),
      .vs      (in_vs),
      .width   (width),
      .height  (height),
      .geom_ok (geom_ok)
   );

endmodule
